// File: rtl/demux_1_4_stream_pkg.sv
// Shared defaults for the 1:N stream demux and its holding slots.
package demux_1_4_stream_pkg;
    localparam int DEFAULT_W = 4;
    localparam int DEFAULT_N = 4;
endpackage

// File: rtl/demux_1_4_stream_slot.sv
// One-entry valid/ready holding register; a push and a pop in the same cycle
// keep the slot full and replace the data.
module stream_slot
    import demux_1_4_stream_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_data;
        end else if (valid && pop_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Steers one valid/ready stream to one of N output slots chosen per beat by
// in_sel; beats addressed past the last channel are swallowed and flagged.
module demux_1_4_stream
    import demux_1_4_stream_pkg::*;
#(
    parameter int  W     = DEFAULT_W,
    parameter int  N     = DEFAULT_N,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [N*W-1:0]   out_data,
    output logic             sel_err
);

    // Padded to the full in_sel range so out-of-range indices read as empty.
    localparam int NP = 1 << SEL_W;

    logic [N-1:0]  full;
    logic [N-1:0]  push;
    logic [NP-1:0] full_pad;
    logic [NP-1:0] ready_pad;
    logic [NP-1:0] sel_map;
    logic          sel_ok;
    logic          accept;

    always_comb begin
        sel_map = '0;
        for (int i = 0; i < N; i++) begin
            sel_map[i] = 1'b1;
        end
    end

    assign full_pad  = NP'(full);
    assign ready_pad = NP'(out_ready);
    assign sel_ok    = sel_map[in_sel];
    assign in_ready  = ~rst & (~sel_ok | ~full_pad[in_sel] | ready_pad[in_sel]);
    assign accept    = in_valid & in_ready;

    for (genvar g = 0; g < N; g++) begin : g_slot
        assign push[g] = accept & sel_ok & (in_sel == SEL_W'(g));

        stream_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (in_data),
            .pop_ready (out_ready[g]),
            .valid     (full[g]),
            .data      (out_data[g*W +: W])
        );
    end

    assign out_valid = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept & ~sel_ok;
        end
    end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: per-channel queue model checked every cycle,
// directed literal checks, and a randomized valid/ready soak.
module tb_demux_1_4_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic        sel_err;

    logic        in_valid3;
    logic        in_ready3;
    logic [3:0]  in_data3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [11:0] out_data3;
    logic        sel_err3;

    int checks   = 0;
    int failures = 0;

    logic [3:0] q[4][$];
    logic       exp_err;
    logic       last_ready;
    logic       cmp_en;

    always #5 clk = ~clk;

    demux_1_4_stream #(.W(4), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err)
    );

    demux_1_4_stream #(.W(4), .N(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .sel_err   (sel_err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare DUT against the queue model, then advance the model
    // with the handshakes that happen at the coming edge.
    task automatic cycle();
        logic [3:0]  ev;
        logic [15:0] ed;
        logic [15:0] mask;
        logic        er;
        logic        acc;
        logic [1:0]  s_sel;
        logic [3:0]  s_data;
        logic [3:0]  s_rdy;
        logic        s_rst;
        #1;
        ev   = '0;
        ed   = '0;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                ev[i]          = 1'b1;
                ed[i*4 +: 4]   = q[i][0];
                mask[i*4 +: 4] = 4'hf;
            end
        end
        er = !rst && (q[in_sel].size() == 0 || out_ready[in_sel]);
        if (cmp_en) begin
            chk("model_in_ready", {31'd0, in_ready}, {31'd0, er});
            chk("model_out_valid", {28'd0, out_valid}, {28'd0, ev});
            chk("model_out_data", {16'd0, out_data & mask}, {16'd0, ed});
            chk("model_sel_err", {31'd0, sel_err}, {31'd0, exp_err});
        end
        last_ready = er;
        acc    = in_valid && er;
        s_sel  = in_sel;
        s_data = in_data;
        s_rdy  = out_ready;
        s_rst  = rst;
        @(posedge clk);
        if (s_rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            exp_err = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ev[i] && s_rdy[i]) void'(q[i].pop_front());
            end
            if (acc) q[s_sel].push_back(s_data);
            exp_err = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = '0;
        out_ready  = '0;
        in_valid3  = 1'b0;
        in_data3   = '0;
        in_sel3    = '0;
        out_ready3 = '0;
        exp_err    = 1'b0;
        last_ready = 1'b0;
        cmp_en     = 1'b0;
        cycle();
        cycle();
        rst    = 1'b0;
        cmp_en = 1'b1;
        chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
        chk("reset_out_data", {16'd0, out_data}, 32'd0);
        chk("reset_sel_err", {31'd0, sel_err}, 32'd0);

        // Reset mid-stream with slots 0 and 2 full.
        in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h1;
        cycle();
        in_sel = 2'd2; in_data = 4'h2;
        cycle();
        in_valid = 1'b0;
        chk("t1_prefill_valid", {28'd0, out_valid}, 32'h5);
        rst = 1'b1;
        #1 chk("t1_ready_in_reset", {31'd0, in_ready}, 32'd0);
        cycle();
        rst = 1'b0;
        chk("t1_out_valid", {28'd0, out_valid}, 32'd0);
        chk("t1_out_data", {16'd0, out_data}, 32'd0);
        chk("t1_sel_err", {31'd0, sel_err}, 32'd0);

        // One beat per clock to each channel with all consumers ready.
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = 4'(4'ha + k);
            #1 chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
            cycle();
            chk("t2_out_valid", {28'd0, out_valid}, 32'(1 << k));
            chk("t2_out_data", {28'd0, out_data[k*4 +: 4]}, 32'(4'ha + k));
        end
        in_valid = 1'b0;
        cycle();

        // Stall channel 1, then release with simultaneous pop and load.
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h5;
        #1 chk("t3_first_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        in_data = 4'h6;
        #1 chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
        cycle();
        cycle();
        chk("t3_hold_data", {28'd0, out_data[7:4]}, 32'h5);
        chk("t3_hold_valid", {28'd0, out_valid}, 32'h2);
        out_ready = 4'b1111;
        #1 chk("t3_release_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        chk("t3_reload_valid", {28'd0, out_valid}, 32'h2);
        chk("t3_reload_data", {28'd0, out_data[7:4]}, 32'h6);
        in_sel = 2'd2; in_data = 4'h7;
        cycle();
        in_valid = 1'b0;
        chk("t3_ch2_valid", {28'd0, out_valid}, 32'h4);
        chk("t3_ch2_data", {28'd0, out_data[11:8]}, 32'h7);
        cycle();

        // A full, blocked slot does not stop other channels.
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 4'he;
        cycle();
        in_sel = 2'd0; in_data = 4'hf;
        #1 chk("t4_other_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("t4_out_valid", {28'd0, out_valid}, 32'h9);
        chk("t4_slot3", {28'd0, out_data[15:12]}, 32'he);
        chk("t4_slot0", {28'd0, out_data[3:0]}, 32'hf);
        out_ready = 4'b1111;
        cycle();

        // N=3: an out-of-range select is accepted, dropped and flagged once.
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 4'h9;
        #1 chk("t5_ready", {31'd0, in_ready3}, 32'd1);
        chk("t5_err_before", {31'd0, sel_err3}, 32'd0);
        cycle();
        in_valid3 = 1'b0;
        chk("t5_err_pulse", {31'd0, sel_err3}, 32'd1);
        chk("t5_no_valid", {29'd0, out_valid3}, 32'd0);
        cycle();
        chk("t5_err_cleared", {31'd0, sel_err3}, 32'd0);
        in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 4'h9;
        cycle();
        in_valid3 = 1'b0;
        chk("t5_ch2_valid", {29'd0, out_valid3}, 32'h4);
        chk("t5_ch2_data", {28'd0, out_data3[11:8]}, 32'h9);
        chk("t5_ch2_no_err", {31'd0, sel_err3}, 32'd0);

        // Random soak; a stalled beat is held stable until accepted.
        for (int n = 0; n < 10000; n++) begin
            if (!(in_valid && !last_ready)) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 4'($urandom);
            end
            out_ready = 4'($urandom);
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 4'b1111;
        cycle();
        cycle();
        chk("final_drained", {28'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
